// File: rtl/ntt_pkg.sv
// Shared types and arithmetic helpers for the NTT stage sequencer.
// mod_mac works on 32-bit operands, so it supports any coefficient width W <= 32.
package ntt_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} ntt_state_e;

  localparam int unsigned MAC_W = 32;
  localparam int unsigned SUM_W = 2 * MAC_W + 1;

  // Reverse the low 'bits' bits of v.
  function automatic int unsigned bitrev(input int unsigned v, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 32'd1);
    return r;
  endfunction

  // (a + b*w) mod q. The product and the sum are kept at full width so nothing wraps.
  function automatic logic [MAC_W-1:0] mod_mac(input logic [MAC_W-1:0] a,
                                                input logic [MAC_W-1:0] b,
                                                input logic [MAC_W-1:0] w,
                                                input logic [MAC_W-1:0] q);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b) * SUM_W'(w);
    return MAC_W'(sum % SUM_W'(q));
  endfunction

endpackage

// File: rtl/ntt_stage_sequencer_butterfly.sv
// mod_butterfly2: combinational 2-point modular butterfly.
// x = (a + b*w) mod q, y = (a + b*(q-w)) mod q. w = 0 gives q-w = q, which is still legal.
module mod_butterfly2
  import ntt_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] w,
  input  logic [W-1:0] q,
  output logic [W-1:0] x,
  output logic [W-1:0] y
);

  logic [W-1:0] w_neg;

  // Both butterfly legs in one combinational pass.
  always_comb begin
    w_neg = q - w;
    x     = W'(mod_mac(MAC_W'(a), MAC_W'(b), MAC_W'(w), MAC_W'(q)));
    y     = W'(mod_mac(MAC_W'(a), MAC_W'(b), MAC_W'(w_neg), MAC_W'(q)));
  end

endmodule

// File: rtl/ntt_stage_sequencer.sv
// ntt_stage_sequencer: in-place radix-2 NTT over an N-entry register bank.
// The design loads N words, runs N/2*log2(N) butterfly cycles and then drains
// the results in natural order.
// Configuration macro NTT_BITREV_EN: when it is defined, load addresses are
// bit-reversed, so the caller supplies the input in natural order. When it is
// undefined, the caller supplies the input already in bit-reversed order.
module ntt_stage_sequencer
  import ntt_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int W    = 8,
  localparam int LOGN = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    cfg_mod,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  output logic [LOGN-2:0] tw_addr,
  input  logic [W-1:0]    tw_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic            busy,
  output logic            done
);

  localparam int HALF = N / 2;
  localparam int KW   = LOGN - 1;
  localparam int SW   = $clog2(LOGN);

  ntt_state_e      state, state_nxt;
  logic [W-1:0]    bank [N];
  logic [W-1:0]    q_reg;
  logic [LOGN-1:0] idx;
  logic [KW-1:0]   k;
  logic [SW-1:0]   stage;

  logic            in_fire, out_fire;
  logic            idx_last, k_last, stage_last;
  logic [LOGN-1:0] k_ext, span, j, addr_a, addr_b, wr_addr;
  logic [KW-1:0]   tw_idx;
  logic [W-1:0]    bf_x, bf_y;

  assign idx_last   = (idx == LOGN'(N - 1));
  assign k_last     = (k == KW'(HALF - 1));
  assign stage_last = (stage == SW'(LOGN - 1));

  // Butterfly pair, twiddle index and load write address for the current counters.
  always_comb begin
    k_ext  = {1'b0, k};
    span   = LOGN'(1) << stage;
    j      = k_ext & (span - LOGN'(1));
    addr_a = (((k_ext >> stage) << stage) << 1) + j;
    addr_b = addr_a + span;
    tw_idx = KW'(j) << (LOGN - 1 - int'(stage));
`ifdef NTT_BITREV_EN
    wr_addr = LOGN'(bitrev(32'(idx), LOGN));
`else
    wr_addr = idx;
`endif
  end

  mod_butterfly2 #(.W(W)) u_bf (
    .a (bank[addr_a]),
    .b (bank[addr_b]),
    .w (tw_data),
    .q (q_reg),
    .x (bf_x),
    .y (bf_y)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs.
  // NOTE: every output gets a default before the case statement, so no path can leave a latch behind.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    in_fire   = 1'b0;
    out_valid = 1'b0;
    out_fire  = 1'b0;
    out_data  = '0;
    busy      = 1'b1;
    done      = 1'b0;
    tw_addr   = '0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = rst_n;
        in_fire  = in_valid && rst_n;
        if (in_fire) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = rst_n;
        in_fire  = in_valid && rst_n;
        if (in_fire && idx_last) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        tw_addr = tw_idx;
        if (k_last && stage_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = bank[idx];
        out_fire  = out_ready;
        if (out_ready && idx_last) begin
          done      = rst_n;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bank, modulus latch and the idx/k/stage counters.
  // NOTE: the bank is a small register array (not a RAM macro), so it is cleared on reset to drop partial frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) bank[i] <= '0;
      q_reg <= '0;
      idx   <= '0;
      k     <= '0;
      stage <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so the butterfly reads this cycle's bank values and not its own writes.
      if (in_fire) begin
        bank[wr_addr] <= in_data;
        idx           <= idx + LOGN'(1);
        if (state == IDLE) q_reg <= cfg_mod;
      end
      if (state == COMPUTE) begin
        bank[addr_a] <= bf_x;
        bank[addr_b] <= bf_y;
        k            <= k + KW'(1);
        if (k_last) stage <= stage_last ? '0 : stage + SW'(1);
      end
      if (out_fire) idx <= idx + LOGN'(1);
    end
  end

endmodule
